// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: radix-2 DIF single-path-delay-feedback FFT stage with twiddle multiply and saturation flag
module fft_sdf_stage #(
  parameter int DBW = 8,
  parameter int CBW = 4,
  parameter int STG = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [2*DBW-1:0]        din,
  input  logic                    inverse,
  input  logic [DBW*(2**CBW)-1:0] trigon,
  output logic                    out_valid,
  output logic [2*DBW-1:0]        dout,
  output logic                    sat
);
  localparam int D  = 2**(CBW-1-STG);
  localparam int AW = (CBW-1-STG) > 0 ? CBW-1-STG : 1;
  localparam int PW = 2*DBW+2;
  localparam logic [CBW-1:0] DL = CBW'(D);
  localparam logic signed [PW-1:0] MAXV = PW'(2**(DBW-1)-1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  localparam logic signed [PW-1:0] RND  = PW'(2**(DBW-2));
  localparam logic signed [DBW+1:0] ONE = 1;
  logic [CBW-1:0] cnt, fill;
  logic inv_q, inv_eff, phase_b, filled, clip_r, clip_i;
  logic [2*DBW-1:0] mem [D];
  logic [2*DBW-1:0] f, w;
  logic [AW-1:0] ptr;
  logic [CBW-2:0] pl, widx;
  logic signed [DBW-1:0] fr, fi, dr, di, wr, wi, sum_r, sum_i, dif_r, dif_i, mr, mi;
  logic signed [DBW:0] wc;
  logic signed [DBW+1:0] ar, ai, br, bi;
  logic signed [PW-1:0] pr, pi, sr, si;
  // Datapath: butterfly halves for phase B, rounded/saturated twiddle product for phase A
  always_comb begin
    phase_b = cnt[CBW-1-STG];
    ptr     = D == 1 ? '0 : cnt[AW-1:0];
    pl      = (CBW-1)'(cnt[AW-1:0]);
    widx    = D == 1 ? '0 : pl << STG;
    filled  = fill == DL;
    inv_eff = cnt == '0 ? inverse : inv_q;
    f       = mem[ptr];
    w       = trigon[int'(widx)*2*DBW +: 2*DBW];
    {fi, fr} = f;
    {di, dr} = din;
    {wi, wr} = w;
    ar    = (DBW+2)'(fr) + (DBW+2)'(dr) + ONE;
    ai    = (DBW+2)'(fi) + (DBW+2)'(di) + ONE;
    br    = (DBW+2)'(fr) - (DBW+2)'(dr) + ONE;
    bi    = (DBW+2)'(fi) - (DBW+2)'(di) + ONE;
    sum_r = DBW'(ar >>> 1);
    sum_i = DBW'(ai >>> 1);
    dif_r = DBW'(br >>> 1);
    dif_i = DBW'(bi >>> 1);
    wc    = inv_eff ? -(DBW+1)'(wi) : (DBW+1)'(wi);
    pr    = PW'(fr) * PW'(wr) - PW'(fi) * PW'(wc) + RND;
    pi    = PW'(fr) * PW'(wc) + PW'(fi) * PW'(wr) + RND;
    sr    = pr >>> (DBW-1);
    si    = pi >>> (DBW-1);
    clip_r = (sr > MAXV) || (sr < MINV);
    clip_i = (si > MAXV) || (si < MINV);
    mr    = sr > MAXV ? MAXV[DBW-1:0] : sr < MINV ? MINV[DBW-1:0] : sr[DBW-1:0];
    mi    = si > MAXV ? MAXV[DBW-1:0] : si < MINV ? MINV[DBW-1:0] : si[DBW-1:0];
  end
  // Control and registered output: count accepts, track fill, latch inverse at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fill      <= '0;
      inv_q     <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid && filled;
      sat       <= in_valid && filled && !phase_b && (clip_r || clip_i);
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (!filled) fill <= fill + 1'b1;
        if (cnt == '0) inv_q <= inverse;
        if (filled) dout <= phase_b ? {sum_i, sum_r} : {mi, mr};
      end
    end
  end
  // Delay line: phase A stores the input, phase B stores the halved difference
  always_ff @(posedge clk) begin
    if (in_valid) mem[ptr] <= phase_b ? {dif_i, dif_r} : din;
  end
endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb_fft_sdf_stage: directed vector bench for the SDF stage (STG=0 and STG=3 instances)
module tb_fft_sdf_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, inverse = 0, out_valid, sat;
  logic [15:0] din = 0, dout;
  logic [127:0] trigon;
  logic in_valid3 = 0, out_valid3, sat3;
  logic [15:0] din3 = 0, dout3;
  logic [127:0] trigon3;
  int checks = 0, errors = 0;

  typedef struct {
    bit rst;
    logic [15:0] din;
    bit ev;
    logic [15:0] ed;
  } vec_t;
  vec_t tbl[64];

  always #5 clk = ~clk;

  fft_sdf_stage #(.DBW(8), .CBW(4), .STG(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .inverse(inverse),
    .trigon(trigon), .out_valid(out_valid), .dout(dout), .sat(sat));

  fft_sdf_stage #(.DBW(8), .CBW(4), .STG(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .din(din3), .inverse(1'b0),
    .trigon(trigon3), .out_valid(out_valid3), .dout(dout3), .sat(sat3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic acc(input logic v, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic acc3(input logic v, input logic [15:0] d);
    @(negedge clk);
    in_valid3 = v;
    din3 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    in_valid3 = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int twr[8] = '{127, 118, 91, 49, 0, -49, -91, -118};
    int twi[8] = '{0, -49, -91, -118, -128, -118, -91, -49};
    logic [15:0] qa[$], qb[$], smp[32];
    int nv, bad;
    for (int k = 0; k < 8; k++) begin
      trigon[k*16 +: 8] = 8'(twr[k]);
      trigon[k*16+8 +: 8] = 8'(twi[k]);
    end
    trigon3 = trigon;
    trigon3[15:0] = 16'h7F7F;
    for (int i = 0; i < 32; i++) begin
      tbl[i].rst = 0;
      tbl[i].din = (i == 0) ? 16'h0040 : 16'h0000;
      tbl[i].ev  = i >= 8;
      tbl[i].ed  = (i == 8 || i == 16) ? 16'h0020 : 16'h0000;
      tbl[32+i].rst = (i == 0);
      tbl[32+i].din = 16'h0064;
      tbl[32+i].ev  = i >= 8;
      tbl[32+i].ed  = (i >= 16 && i < 24) ? 16'h0000 : 16'h0064;
    end

    repeat (2) @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst dout", {16'b0, dout}, 0);
    chk("rst sat", {31'b0, sat}, 0);
    chk("rst3 out_valid", {31'b0, out_valid3}, 0);
    rst_n = 1;

    for (int i = 0; i < 64; i++) begin
      if (tbl[i].rst) do_reset();
      acc(1, tbl[i].din);
      chk($sformatf("tbl[%0d] valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) chk($sformatf("tbl[%0d] dout", i), {16'b0, dout}, {16'b0, tbl[i].ed});
      chk($sformatf("tbl[%0d] sat", i), {31'b0, sat}, 0);
    end
    acc(0, 0);

    acc3(1, 16'h8080);
    chk("d1 fill valid", {31'b0, out_valid3}, 0);
    acc3(1, 16'h7F7F);
    chk("d1 b valid", {31'b0, out_valid3}, 1);
    chk("d1 b dout", {16'b0, dout3}, 0);
    chk("d1 b sat", {31'b0, sat3}, 0);
    acc3(1, 16'h0000);
    chk("d1 a valid", {31'b0, out_valid3}, 1);
    chk("d1 a dout", {16'b0, dout3}, 32'h8000);
    chk("d1 a sat", {31'b0, sat3}, 1);
    acc3(0, 16'h1234);
    chk("d1 gap valid", {31'b0, out_valid3}, 0);
    chk("d1 gap sat", {31'b0, sat3}, 0);
    chk("d1 gap hold", {16'b0, dout3}, 32'h8000);

    for (int r = 0; r < 2; r++) begin
      do_reset();
      inverse = (r == 1);
      for (int i = 0; i < 32; i++) begin
        if (r == 1 && i == 17) inverse = 0;
        acc(1, (i == 1) ? 16'h0040 : 16'h0000);
        if (i == 17) begin
          chk($sformatf("inv%0d valid", r), {31'b0, out_valid}, 1);
          chk($sformatf("inv%0d p1 dout", r), {16'b0, dout}, r == 1 ? 32'h0C1E : 32'hF41E);
        end
      end
      acc(0, 0);
    end
    inverse = 0;

    for (int i = 0; i < 32; i++) smp[i] = {8'($urandom_range(0, 120) - 60), 8'($urandom_range(0, 120) - 60)};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      acc(1, smp[i]);
      if (out_valid) qa.push_back(dout);
    end
    do_reset();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      while ($urandom_range(0, 99) >= 30) begin
        acc(0, 16'hDEAD);
        if (out_valid) bad++;
      end
      acc(1, smp[i]);
      if (out_valid) qb.push_back(dout);
    end
    acc(0, 0);
    if (out_valid) bad++;
    chk("duty full count", qa.size(), 24);
    chk("duty gap count", qb.size(), 24);
    chk("duty stray valid", bad, 0);
    for (int i = 0; i < qa.size() && i < qb.size(); i++)
      chk($sformatf("duty y[%0d]", i), {16'b0, qb[i]}, {16'b0, qa[i]});

    do_reset();
    for (int i = 0; i < 21; i++) acc(1, 16'h0000);
    chk("pre-rst valid", {31'b0, out_valid}, 1);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid-rst valid", {31'b0, out_valid}, 0);
    chk("mid-rst sat", {31'b0, sat}, 0);
    chk("mid-rst dout", {16'b0, dout}, 0);
    @(negedge clk);
    rst_n = 1;
    nv = 0;
    for (int i = 0; i < 32; i++) begin
      acc(1, (i == 0) ? 16'h0040 : 16'h0000);
      if (i < 8 && out_valid) nv++;
      if (i == 8 || i == 16) chk($sformatf("post-rst y%0d", i), {15'b0, out_valid, dout}, 32'h10020);
      if (i == 9) chk("post-rst y9", {15'b0, out_valid, dout}, 32'h10000);
    end
    chk("post-rst fill", nv, 0);
    acc(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
